// File: rtl/fetch_line_buffer_pkg.sv
// fetch_line_buffer_pkg
//   Shared constants and types for the single-line instruction fetch buffer.
//   FLB_LINE_WORDS : default words per line (power of two, 2..16)
//   FLB_LW         : log2(FLB_LINE_WORDS), width of the word index
//   flb_state_e    : fill controller states
package fetch_line_buffer_pkg;

    localparam int unsigned FLB_LINE_WORDS = 4;
    localparam int unsigned FLB_LW         = $clog2(FLB_LINE_WORDS);

    typedef enum logic {
        sIDLE = 1'b0,
        sFILL = 1'b1
    } flb_state_e;

endpackage

// File: rtl/fetch_line_buffer_store.sv
// fetch_line_store
//   Data array for one cache line: LINE_WORDS x 32-bit words plus one
//   valid bit per word.  Single synchronous write port, combinational read.
//
//   clk, reset_n : clock, synchronous active-low reset (clears valid bits)
//   clear_all    : drop every word-valid bit at the next edge
//   we/widx/wdata: write wdata into word widx and mark it valid
//   ridx         : read index
//   rdata/rvalid : word at ridx and its valid bit
module fetch_line_store #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LW         = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_all,
    input  logic          we,
    input  logic [LW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [LW-1:0] ridx,
    output logic [31:0]   rdata,
    output logic          rvalid
);

    logic [31:0]           words_q [LINE_WORDS];
    logic [LINE_WORDS-1:0] wvalid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wvalid_q <= '0;
        end else begin
            if (clear_all) begin
                wvalid_q <= '0;
            end
            if (we) begin
                wvalid_q[widx] <= 1'b1;
            end
        end
    end

    // Data words need no reset: they are only observed through wvalid_q.
    always_ff @(posedge clk) begin
        if (we) begin
            words_q[widx] <= wdata;
        end
    end

    assign rdata  = words_q[ridx];
    assign rvalid = wvalid_q[ridx];

endmodule

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer
//   Single-line instruction buffer between the core fetch port and a
//   variable-latency instruction memory (req/ack burst fill).  Hits are
//   served combinationally; a miss fills the whole line one word per ack,
//   with stall released as soon as the requested word has arrived.
//   Core data stores that hit the buffered line invalidate it.
//
//   clk, reset_n          : clock, synchronous active-low reset
//   i_addr / i_data       : core fetch word address / instruction (0 on stall)
//   stall                 : requested word not available this cycle
//   st_strobe/st_rw/st_addr : core data port, snooped for stores
//   mem_req/mem_addr      : fill request and word address (held until ack)
//   mem_ack/mem_rdata     : beat accepted, data valid in the same cycle
//
//   state | meaning
//   sIDLE | no fill in flight; a miss starts one at the next edge
//   sFILL | burst in flight; beat_q counts accepted words
module fetch_line_buffer
    import fetch_line_buffer_pkg::*;
#(
    parameter int unsigned LINE_WORDS = FLB_LINE_WORDS,
    parameter int unsigned LW         = FLB_LW
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        stall,
    input  logic        st_strobe,
    input  logic        st_rw,
    input  logic [31:0] st_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TW = 32 - LW;

    flb_state_e     state_q, state_d;
    logic           line_valid_q, line_valid_d;
    logic [TW-1:0]  tag_q, tag_d;
    logic [LW-1:0]  beat_q, beat_d;
    logic           refetch_q, refetch_d;
    logic           mem_req_q, mem_req_d;
    logic [31:0]    mem_addr_q, mem_addr_d;

    logic [TW-1:0]  req_tag;
    logic [LW-1:0]  req_idx;
    logic [TW-1:0]  st_tag;
    logic           st_off_unused;
    logic           miss;
    logic           snoop_hit;
    logic           beat_fire;
    logic           last_beat;
    logic           fill_start;
    logic [31:0]    line_rdata;
    logic           line_rvalid;
    logic           hit;

    assign req_tag       = i_addr[31:LW];
    assign req_idx       = i_addr[LW-1:0];
    assign st_tag        = st_addr[31:LW];
    assign st_off_unused = ^st_addr[LW-1:0];

    assign miss       = !line_valid_q || (tag_q != req_tag);
    assign snoop_hit  = st_strobe && st_rw && line_valid_q && (st_tag == tag_q);
    assign beat_fire  = (state_q == sFILL) && mem_req_q && mem_ack;
    assign last_beat  = (beat_q == LW'(LINE_WORDS - 1));
    assign fill_start = (state_q == sIDLE) && miss;

    fetch_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .LW         (LW)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_all (fill_start),
        .we        (beat_fire),
        .widx      (beat_q),
        .wdata     (mem_rdata),
        .ridx      (req_idx),
        .rdata     (line_rdata),
        .rvalid    (line_rvalid)
    );

    // Per-word valid gives early restart: the requested word becomes a hit
    // the cycle after it is written, while the rest of the line still fills.
    assign hit    = line_valid_q && (tag_q == req_tag) && line_rvalid;
    assign stall  = !hit;
    assign i_data = hit ? line_rdata : 32'h0;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= sIDLE;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            beat_q       <= '0;
            refetch_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            beat_q       <= beat_d;
            refetch_q    <= refetch_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            sIDLE: begin
                if (miss) begin
                    state_d = sFILL;
                end
            end
            sFILL: begin
                if (beat_fire && last_beat) begin
                    state_d = sIDLE;
                end
            end
            default: state_d = sIDLE;
        endcase
    end

    always_comb begin
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        beat_d       = beat_q;
        refetch_d    = refetch_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            sIDLE: begin
                if (miss) begin
                    // Fill start takes priority; a same-cycle snoop was
                    // compared against the outgoing tag and is dropped.
                    tag_d        = req_tag;
                    line_valid_d = 1'b1;
                    beat_d       = '0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {req_tag, {LW{1'b0}}};
                end else if (snoop_hit) begin
                    line_valid_d = 1'b0;
                end
            end
            sFILL: begin
                // A store into the line being filled cannot abort the burst;
                // remember it and drop the line once the burst is done.
                if (snoop_hit) begin
                    refetch_d = 1'b1;
                end
                if (beat_fire) begin
                    if (last_beat) begin
                        mem_req_d = 1'b0;
                        beat_d    = '0;
                        if (refetch_q || snoop_hit) begin
                            line_valid_d = 1'b0;
                            refetch_d    = 1'b0;
                        end
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd1;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule
